// File: rtl/dfp128_unpack_seq.sv
// Sequential decimal128 (DPD) unpacker: comb-field decode on accept, then DPC declets per cycle.
module dfp128_unpack_seq #(
  parameter int unsigned DPC = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ce,
  input  logic         i_valid,
  output logic         i_ready,
  input  logic [127:0] i,
  output logic         o_valid,
  input  logic         o_ready,
  output logic         o_nan,
  output logic         o_qnan,
  output logic         o_snan,
  output logic         o_infinity,
  output logic         o_sign,
  output logic [13:0]  o_exp,
  output logic [135:0] o_sig
);

  localparam int unsigned NDEC  = 11;
  localparam int unsigned CNT_W = 5;
  localparam int unsigned EXP_W = 14;
  localparam int unsigned SIG_W = 136;
  localparam int unsigned DEC_W = 110;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [DEC_W-1:0]   word, word_nxt;
  logic               o_valid_nxt;
  logic               o_nan_nxt, o_qnan_nxt, o_snan_nxt, o_infinity_nxt, o_sign_nxt;
  logic [EXP_W-1:0]   o_exp_nxt;
  logic [SIG_W-1:0]   o_sig_nxt;

  logic [4:0]         g;
  logic [11:0]        cont;

  assign g       = i[126:122];
  assign cont    = i[121:110];
  assign i_ready = (state == IDLE);

  // One DPD declet (p q r s t u v w x y, p = bit 9) to three BCD digits; non-canonical codes decode to 8/9.
  function automatic logic [11:0] dpd_dec(input logic [9:0] d);
    logic p, q, r, s, t, u, v, w, x, y;
    logic [11:0] res;
    {p, q, r, s, t, u, v, w, x, y} = d;
    res = '0;
    casez ({v, w, x, s, t})
      5'b0????: res = {1'b0, p, q, r, 1'b0, s, t, u, 1'b0, w, x, y};
      5'b100??: res = {1'b0, p, q, r, 1'b0, s, t, u, 3'b100, y};
      5'b101??: res = {1'b0, p, q, r, 3'b100, u, 1'b0, s, t, y};
      5'b110??: res = {3'b100, r, 1'b0, s, t, u, 1'b0, p, q, y};
      5'b11100: res = {3'b100, r, 3'b100, u, 1'b0, p, q, y};
      5'b11101: res = {3'b100, r, 1'b0, p, q, u, 3'b100, y};
      5'b11110: res = {1'b0, p, q, r, 3'b100, u, 3'b100, y};
      default:  res = {3'b100, r, 3'b100, u, 3'b100, y};
    endcase
    return res;
  endfunction

  // Next-state and next-output logic; everything holds unless ce is high.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    word_nxt       = word;
    o_valid_nxt    = o_valid;
    o_nan_nxt      = o_nan;
    o_qnan_nxt     = o_qnan;
    o_snan_nxt     = o_snan;
    o_infinity_nxt = o_infinity;
    o_sign_nxt     = o_sign;
    o_exp_nxt      = o_exp;
    o_sig_nxt      = o_sig;
    if (ce) begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            state_nxt      = DECODE;
            cnt_nxt        = '0;
            word_nxt       = i[109:0];
            o_sign_nxt     = i[127];
            o_nan_nxt      = 1'b0;
            o_qnan_nxt     = 1'b0;
            o_snan_nxt     = 1'b0;
            o_infinity_nxt = 1'b0;
            o_sig_nxt      = '0;
            if (g[4:3] != 2'b11) begin
              o_exp_nxt           = {g[4:3], cont};
              o_sig_nxt[135:132]  = {1'b0, g[2:0]};
            end else if (g[2:1] != 2'b11) begin
              o_exp_nxt           = {g[2:1], cont};
              o_sig_nxt[135:132]  = {3'b100, g[0]};
            end else if (!g[0]) begin
              o_exp_nxt      = 14'h3FFF;
              o_infinity_nxt = 1'b1;
            end else begin
              o_exp_nxt  = 14'h3FFF;
              o_nan_nxt  = 1'b1;
              o_snan_nxt = i[121];
              o_qnan_nxt = ~i[121];
            end
          end
        end
        DECODE: begin
          for (int unsigned k = 0; k < NDEC; k++) begin
            if (!o_infinity && (k >= 32'(cnt)) && (k < 32'(cnt) + DPC))
              o_sig_nxt[12*k +: 12] = dpd_dec(word[10*k +: 10]);
          end
          cnt_nxt = cnt + CNT_W'(DPC);
          if (32'(cnt) + DPC >= NDEC) begin
            state_nxt   = DONE;
            o_valid_nxt = 1'b1;
          end
        end
        DONE: begin
          if (o_ready) begin
            state_nxt   = IDLE;
            o_valid_nxt = 1'b0;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      word       <= '0;
      o_valid    <= 1'b0;
      o_nan      <= 1'b0;
      o_qnan     <= 1'b0;
      o_snan     <= 1'b0;
      o_infinity <= 1'b0;
      o_sign     <= 1'b0;
      o_exp      <= '0;
      o_sig      <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      word       <= word_nxt;
      o_valid    <= o_valid_nxt;
      o_nan      <= o_nan_nxt;
      o_qnan     <= o_qnan_nxt;
      o_snan     <= o_snan_nxt;
      o_infinity <= o_infinity_nxt;
      o_sign     <= o_sign_nxt;
      o_exp      <= o_exp_nxt;
      o_sig      <= o_sig_nxt;
    end
  end

endmodule

// File: tb/tb_dfp128_unpack_seq.sv
// Scoreboard bench for dfp128_unpack_seq: DPC=1 and DPC=11 instances, directed vectors.
module tb_dfp128_unpack_seq;

  typedef struct packed {
    logic         nan;
    logic         qnan;
    logic         snan;
    logic         inf;
    logic         sign;
    logic [13:0]  exp;
    logic [135:0] sig;
  } res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, ce;
  logic         i_valid, i_ready, o_valid, o_ready;
  logic [127:0] i_w;
  logic         o_nan, o_qnan, o_snan, o_infinity, o_sign;
  logic [13:0]  o_exp;
  logic [135:0] o_sig;

  logic         i_valid2, i_ready2, o_valid2, o_ready2;
  logic [127:0] i_w2;
  logic         o_nan2, o_qnan2, o_snan2, o_infinity2, o_sign2;
  logic [13:0]  o_exp2;
  logic [135:0] o_sig2;

  res_t exp_q[$];
  res_t exp_q2[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  dfp128_unpack_seq #(.DPC(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .ce(ce),
    .i_valid(i_valid), .i_ready(i_ready), .i(i_w),
    .o_valid(o_valid), .o_ready(o_ready),
    .o_nan(o_nan), .o_qnan(o_qnan), .o_snan(o_snan), .o_infinity(o_infinity),
    .o_sign(o_sign), .o_exp(o_exp), .o_sig(o_sig)
  );

  dfp128_unpack_seq #(.DPC(11)) u_dut11 (
    .clk(clk), .rst_n(rst_n), .ce(ce),
    .i_valid(i_valid2), .i_ready(i_ready2), .i(i_w2),
    .o_valid(o_valid2), .o_ready(o_ready2),
    .o_nan(o_nan2), .o_qnan(o_qnan2), .o_snan(o_snan2), .o_infinity(o_infinity2),
    .o_sign(o_sign2), .o_exp(o_exp2), .o_sig(o_sig2)
  );

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic res_t mk(input logic nan, input logic qnan, input logic snan, input logic inf,
                              input logic sign, input logic [13:0] e, input logic [135:0] s);
    res_t r;
    r = '{nan: nan, qnan: qnan, snan: snan, inf: inf, sign: sign, exp: e, sig: s};
    return r;
  endfunction

  function automatic logic [127:0] pack_word(input logic s, input logic [4:0] g,
                                             input logic [11:0] c, input logic [109:0] d);
    return {s, g, c, d};
  endfunction

  // Monitor for the DPC=1 instance: compare on each output handshake.
  always @(negedge clk) begin : mon1
    res_t a, e;
    if (rst_n && ce && o_valid && o_ready) begin
      a = mk(o_nan, o_qnan, o_snan, o_infinity, o_sign, o_exp, o_sig);
      if (exp_q.size() == 0) begin
        check("dpc1_unexpected_output", 160'(1), 160'(0));
      end else begin
        e = exp_q.pop_front();
        check("dpc1_result", 160'(a), 160'(e));
      end
    end
  end

  // Monitor for the DPC=11 instance.
  always @(negedge clk) begin : mon2
    res_t a, e;
    if (rst_n && ce && o_valid2 && o_ready2) begin
      a = mk(o_nan2, o_qnan2, o_snan2, o_infinity2, o_sign2, o_exp2, o_sig2);
      if (exp_q2.size() == 0) begin
        check("dpc11_unexpected_output", 160'(1), 160'(0));
      end else begin
        e = exp_q2.pop_front();
        check("dpc11_result", 160'(a), 160'(e));
      end
    end
  end

  // Issue one word, measure accept-to-valid latency (optional ce gap), then release it.
  task automatic send(input bit d11, input logic [127:0] w, input res_t e, input int lat,
                      input int gap_at, input int gap_len, input string name);
    int cyc;
    @(posedge clk); #1;
    if (d11) begin i_w2 = w; i_valid2 = 1'b1; exp_q2.push_back(e); end
    else     begin i_w  = w; i_valid  = 1'b1; exp_q.push_back(e);  end
    @(posedge clk); #1;
    i_valid  = 1'b0;
    i_valid2 = 1'b0;
    cyc = 0;
    while (!(d11 ? o_valid2 : o_valid) && cyc < 60) begin
      if (cyc == gap_at) ce = 1'b0;
      if (cyc == gap_at + gap_len) ce = 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    ce = 1'b1;
    check({name, "_latency"}, 160'(cyc), 160'(lat));
    @(posedge clk); #1;
  endtask

  localparam logic [127:0] W1    = 128'h2208_0000_0000_0000_0000_0000_0000_0001;
  localparam logic [127:0] WINF  = 128'h7800_0000_0000_0000_0000_0000_0000_0000;
  localparam logic [127:0] WSNAN = 128'h7E00_0000_0000_0000_0000_0000_0000_0005;
  localparam logic [127:0] WQNAN = 128'h7C00_0000_0000_0000_0000_0000_0000_0005;
  localparam logic [109:0] DMIX  = {10'h000, 10'h16E, 10'h3FF, 10'h0FF, 10'h2DE, 10'h23E,
                                    10'h31E, 10'h3CD, 10'h1CB, 10'h009, 10'h123};

  initial begin
    logic [127:0] w4, wmix, wneg;
    res_t e1, einf, esnan, eqnan, e4, emix, eneg;
    int seen;

    w4   = pack_word(1'b1, 5'b11001, 12'h000, {11{10'h0FF}});
    wmix = pack_word(1'b0, 5'b00111, 12'h001, DMIX);
    wneg = pack_word(1'b1, 5'b11101, 12'hABC, 110'h123);
    e1    = mk(0, 0, 0, 0, 0, 14'h1820, 136'h1);
    einf  = mk(0, 0, 0, 1, 0, 14'h3FFF, 136'h0);
    esnan = mk(1, 0, 1, 0, 0, 14'h3FFF, 136'h5);
    eqnan = mk(1, 1, 0, 0, 0, 14'h3FFF, 136'h5);
    e4    = mk(0, 0, 0, 0, 1, 14'h0000, {34{4'h9}});
    emix  = mk(0, 0, 0, 0, 0, 14'h0001, 136'h7000888999999598858896947385009223);
    eneg  = mk(0, 0, 0, 0, 1, 14'h2ABC, (136'h9 << 132) | 136'h223);

    rst_n = 1'b0; ce = 1'b0;
    i_valid = 1'b0; o_ready = 1'b1; i_w = '0;
    i_valid2 = 1'b0; o_ready2 = 1'b1; i_w2 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_o_valid", 160'(o_valid), 160'(0));
    check("reset_i_ready", 160'(i_ready), 160'(1));
    check("reset_data", 160'({o_nan, o_qnan, o_snan, o_infinity, o_sign, o_exp, o_sig}), 160'(0));
    check("reset_dpc11_ready", 160'({i_ready2, o_valid2}), 160'(2'b10));
    rst_n = 1'b1; ce = 1'b1;

    send(0, W1,    e1,    11, -1, 0, "one");
    send(0, WINF,  einf,  11, -1, 0, "inf");
    send(0, WSNAN, esnan, 11, -1, 0, "snan");
    send(0, WQNAN, eqnan, 11, -1, 0, "qnan");
    send(0, w4,    e4,    11, -1, 0, "nines");
    send(0, wmix,  emix,  11, -1, 0, "mixed");
    send(0, wneg,  eneg,  11, -1, 0, "neg");
    send(1, w4,    e4,    1,  -1, 0, "dpc11_nines");
    send(1, wmix,  emix,  1,  -1, 0, "dpc11_mixed");
    send(1, WSNAN, esnan, 1,  -1, 0, "dpc11_snan");

    // Backpressure: result held, second word waits for the release cycle.
    @(posedge clk); #1;
    o_ready = 1'b0; i_w = W1; i_valid = 1'b1; exp_q.push_back(e1);
    @(posedge clk); #1;
    check("bp_accept_ready", 160'(i_ready), 160'(0));
    i_w = wmix; exp_q.push_back(emix);
    seen = 0;
    while (!o_valid && seen < 60) begin @(posedge clk); #1; seen++; end
    check("bp_first_latency", 160'(seen), 160'(11));
    for (int k = 0; k < 5; k++) begin
      check("bp_hold", 160'({o_valid, i_ready, o_exp, o_sig}), 160'({1'b1, 1'b0, e1.exp, e1.sig}));
      @(posedge clk); #1;
    end
    o_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release", 160'({o_valid, i_ready}), 160'(2'b01));
    @(posedge clk); #1;
    check("bp_second_accept", 160'(i_ready), 160'(0));
    i_valid = 1'b0;
    seen = 0;
    while (!o_valid && seen < 60) begin @(posedge clk); #1; seen++; end
    check("bp_second_latency", 160'(seen), 160'(11));
    @(posedge clk); #1;

    // Reset during the fifth decode cycle discards the word.
    i_w = w4; i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_state", 160'({o_valid, i_ready}), 160'(2'b01));
    check("midrst_data", 160'({o_exp, o_sig}), 160'(0));
    rst_n = 1'b1;
    seen = 0;
    repeat (15) begin @(posedge clk); #1; if (o_valid) seen++; end
    check("midrst_no_output", 160'(seen), 160'(0));

    // ce low for three decode cycles stretches latency by three.
    send(0, wmix, emix, 14, 3, 3, "ce_gap");

    repeat (3) @(posedge clk);
    #1;
    check("dpc1_drain", 160'(exp_q.size()), 160'(0));
    check("dpc11_drain", 160'(exp_q2.size()), 160'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
